cordic_step_engine: RTL and testbench

Sequential CORDIC micro-rotation datapath that consumes the redundant rotation-direction pair (d, dn) produced by the combinational CORDIC direction-decision unit. Each cycle it exports its current iteration index and the leading digits of x, y and z to that unit, samples the returned d/dn, and applies one shift-add micro-rotation. It is the register-and-arithmetic half of the iterative CORDIC; the decision unit stays external and purely combinational.

---
 rtl/cordic_pkg.sv | 40 ++++
 rtl/cordic_sat.sv | 28 ++
 rtl/cordic_step_engine.sv | 154 +++++++++++++++
 tb/tb_cordic_step_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC step engine.
// The arctangent ROM is scaled for 16-bit angles where 2^15 represents pi.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // {d,dn} direction codes from the decision unit
    localparam logic [1:0] DIR_SKIP = 2'b00;
    localparam logic [1:0] DIR_NEG  = 2'b01;
    localparam logic [1:0] DIR_POS  = 2'b10;
    localparam logic [1:0] DIR_ILL  = 2'b11;

    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd0:    val = 16'd8192;
            4'd1:    val = 16'd4836;
            4'd2:    val = 16'd2555;
            4'd3:    val = 16'd1297;
            4'd4:    val = 16'd651;
            4'd5:    val = 16'd326;
            4'd6:    val = 16'd163;
            4'd7:    val = 16'd81;
            4'd8:    val = 16'd41;
            4'd9:    val = 16'd20;
            4'd10:   val = 16'd10;
            4'd11:   val = 16'd5;
            4'd12:   val = 16'd3;
            4'd13:   val = 16'd1;
            4'd14:   val = 16'd1;
            default: val = 16'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cordic_sat.sv
// Clamps a WIDTH+2 bit signed value into the WIDTH-bit signed range.
module cordic_sat
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH+1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    logic w_fits;

    // The value fits when the three top bits are pure sign extension
    assign w_fits = (i_val[WIDTH+1:WIDTH-1] == 3'b000) ||
                    (i_val[WIDTH+1:WIDTH-1] == 3'b111);

    always_comb begin
        o_val = i_val[WIDTH-1:0];
        if (!w_fits) begin
            if (i_val[WIDTH+1]) begin
                o_val = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                o_val = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/cordic_step_engine.sv
// Register-and-arithmetic half of an iterative CORDIC: one shift-add
// micro-rotation per cycle, steered by an external direction-decision unit.
module cordic_step_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    input  logic             d,
    input  logic             dn,
    output logic [3:0]       iter,
    output logic [3:0]       x_msb,
    output logic [3:0]       y_msb,
    output logic [2:0]       z_msb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out
);

    localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

    state_t r_state;
    state_t w_state_next;

    logic signed [WIDTH+1:0] r_xr;
    logic signed [WIDTH+1:0] r_yr;
    logic signed [WIDTH:0]   r_zr;
    logic [3:0]              r_iter;
    logic                    r_err;
    logic [WIDTH-1:0]        r_x_out;
    logic [WIDTH-1:0]        r_y_out;
    logic [WIDTH-1:0]        r_z_out;

    logic [1:0]              w_dir;
    logic signed [WIDTH+1:0] w_sh_x;
    logic signed [WIDTH+1:0] w_sh_y;
    logic signed [WIDTH:0]   w_atan;
    logic signed [WIDTH+1:0] w_xr_next;
    logic signed [WIDTH+1:0] w_yr_next;
    logic signed [WIDTH:0]   w_zr_next;
    logic                    w_illegal;
    logic                    w_load;
    logic                    w_last;
    logic [WIDTH+1:0]        w_z_ext;
    logic [WIDTH-1:0]        w_x_sat;
    logic [WIDTH-1:0]        w_y_sat;
    logic [WIDTH-1:0]        w_z_sat;

    assign w_dir  = {d, dn};
    assign w_last = (r_iter == LAST_ITER);
    assign w_load = start && (r_state != ST_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_ITER;
            ST_ITER: if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_ITER : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sh_x    = r_xr >>> r_iter;
        w_sh_y    = r_yr >>> r_iter;
        w_atan    = $signed((WIDTH+1)'(atan_lut(r_iter)));
        w_xr_next = r_xr;
        w_yr_next = r_yr;
        w_zr_next = r_zr;
        w_illegal = 1'b0;
        case (w_dir)
            DIR_POS: begin
                w_xr_next = r_xr - w_sh_y;
                w_yr_next = r_yr + w_sh_x;
                w_zr_next = r_zr - w_atan;
            end
            DIR_NEG: begin
                w_xr_next = r_xr + w_sh_y;
                w_yr_next = r_yr - w_sh_x;
                w_zr_next = r_zr + w_atan;
            end
            DIR_ILL: w_illegal = 1'b1;
            default: ;
        endcase
    end

    // Results are taken from the post-update values so the final
    // micro-rotation lands in the outputs on the same edge that enters DONE.
    assign w_z_ext = {w_zr_next[WIDTH], w_zr_next};

    cordic_sat #(.WIDTH(WIDTH)) u_sat_x (.i_val(w_xr_next), .o_val(w_x_sat));
    cordic_sat #(.WIDTH(WIDTH)) u_sat_y (.i_val(w_yr_next), .o_val(w_y_sat));
    cordic_sat #(.WIDTH(WIDTH)) u_sat_z (.i_val(w_z_ext),   .o_val(w_z_sat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xr    <= '0;
            r_yr    <= '0;
            r_zr    <= '0;
            r_iter  <= '0;
            r_err   <= 1'b0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
        end else if (w_load) begin
            r_xr   <= {{2{x_in[WIDTH-1]}}, x_in};
            r_yr   <= {{2{y_in[WIDTH-1]}}, y_in};
            r_zr   <= {z_in[WIDTH-1], z_in};
            r_iter <= '0;
            r_err  <= 1'b0;
        end else if (r_state == ST_ITER) begin
            r_xr  <= w_xr_next;
            r_yr  <= w_yr_next;
            r_zr  <= w_zr_next;
            r_err <= r_err | w_illegal;
            if (w_last) begin
                r_x_out <= w_x_sat;
                r_y_out <= w_y_sat;
                r_z_out <= w_z_sat;
            end else begin
                r_iter <= r_iter + 4'd1;
            end
        end
    end

    assign iter  = r_iter;
    assign x_msb = r_xr[WIDTH+1:WIDTH-2];
    assign y_msb = r_yr[WIDTH+1:WIDTH-2];
    assign z_msb = r_zr[WIDTH:WIDTH-2];
    assign busy  = (r_state == ST_ITER);
    assign done  = (r_state == ST_DONE);
    assign err   = r_err;
    assign x_out = r_x_out;
    assign y_out = r_y_out;
    assign z_out = r_z_out;

endmodule

// File: tb/tb_cordic_step_engine.sv
// Directed bench for cordic_step_engine; a table stands in for the direction
// decision unit and a scoreboard queue holds the expected results per operation.
module tb_cordic_step_engine;

    localparam int WIDTH = 16;
    localparam int ITER  = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic signed [WIDTH-1:0] z_in = '0;
    logic d, dn;
    logic [3:0] iter, x_msb, y_msb;
    logic [2:0] z_msb;
    logic busy, done, err;
    logic signed [WIDTH-1:0] x_out, y_out, z_out;

    typedef struct {
        logic signed [WIDTH-1:0] x;
        logic signed [WIDTH-1:0] y;
        logic signed [WIDTH-1:0] z;
        logic                    e;
    } exp_t;

    exp_t sb[$];
    logic [1:0] dir_tab [16];
    int atan_ref [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                          41, 20, 10, 5, 3, 1, 1, 0};
    int checks = 0;
    int errors = 0;
    logic signed [WIDTH-1:0] last_x = '0;

    assign {d, dn} = dir_tab[iter];

    always #5 clk = ~clk;

    cordic_step_engine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .d(d), .dn(dn),
        .iter(iter), .x_msb(x_msb), .y_msb(y_msb), .z_msb(z_msb),
        .busy(busy), .done(done), .err(err),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic exp_t model(input int x, input int y, input int z);
        longint xr = x, yr = y, zr = z, tx;
        exp_t r;
        r.e = 1'b0;
        for (int i = 0; i < ITER; i++) begin
            case (dir_tab[i])
                2'b10: begin tx = xr - (yr >>> i); yr = yr + (xr >>> i); xr = tx; zr -= atan_ref[i]; end
                2'b01: begin tx = xr + (yr >>> i); yr = yr - (xr >>> i); xr = tx; zr += atan_ref[i]; end
                2'b11: r.e = 1'b1;
                default: ;
            endcase
        end
        r.x = 16'(sat16(xr));
        r.y = 16'(sat16(yr));
        r.z = 16'(sat16(zr));
        return r;
    endfunction

    task automatic set_dirs(input logic [1:0] code, input int at, input logic [1:0] other);
        for (int i = 0; i < 16; i++) dir_tab[i] = (i == at) ? code : other;
    endtask

    // Drive start for one edge (or keep it high), then sit on the first busy cycle.
    task automatic launch(input int x, input int y, input int z, input exp_t e, input bit keep);
        @(negedge clk);
        x_in = 16'(x); y_in = 16'(y); z_in = 16'(z);
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        if (!keep) start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("iter_after_start", 32'(iter), 0);
        chk("outputs_held", x_out, last_x);
    endtask

    task automatic wait_done(input int pulse_at);
        int cycles = 1;
        bit pulsed = 0;
        exp_t e;
        while (!done && cycles < 40) begin
            if (pulsed) begin
                start = 1'b0;
                pulsed = 0;
                chk("iter_after_ignored_start", 32'(iter), pulse_at + 1);
            end else if (busy && int'(iter) == pulse_at) begin
                start = 1'b1;
                x_in = 16'sd7; y_in = 16'sd7; z_in = 16'sd7;
                pulsed = 1;
            end
            @(negedge clk);
            cycles++;
        end
        chk("latency", cycles, ITER + 1);
        chk("busy_in_done", 32'(busy), 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("x_out", x_out, e.x);
            chk("y_out", y_out, e.y);
            chk("z_out", z_out, e.z);
            chk("err", 32'(err), 32'(e.e));
            $display("op x=%0d y=%0d z=%0d err=%0d cycles=%0d", x_out, y_out, z_out, err, cycles);
            last_x = e.x;
        end
    endtask

    initial begin
        exp_t e;
        int done_seen;
        set_dirs(2'b00, 0, 2'b00);
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_iter", 32'(iter), 0);
        chk("reset_x_out", x_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // Skip only
        set_dirs(2'b00, 0, 2'b00);
        e = '{16384, -5000, 1234, 1'b0};
        launch(16384, -5000, 1234, e, 0);
        wait_done(-1);

        // Single rotation at iteration 0
        set_dirs(2'b10, 0, 2'b00);
        e = '{16384, 16384, -8192, 1'b0};
        launch(16384, 0, 0, e, 0);
        wait_done(-1);

        // Saturation of x
        set_dirs(2'b01, 0, 2'b00);
        e = '{32767, 0, 8192, 1'b0};
        launch(32767, 32767, 0, e, 0);
        wait_done(-1);

        // Illegal code at iteration 3
        set_dirs(2'b11, 3, 2'b00);
        e = '{1000, 2000, 300, 1'b1};
        launch(1000, 2000, 300, e, 0);
        wait_done(-1);

        // Mixed directions through all iterations, start pulsed at iter 5
        for (int i = 0; i < 16; i++) dir_tab[i] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        dir_tab[4] = 2'b00;
        begin
            int xi = int'($urandom_range(0, 16000)) - 8000;
            int yi = int'($urandom_range(0, 16000)) - 8000;
            int zi = int'($urandom_range(0, 8000)) - 4000;
            e = model(xi, yi, zi);
            launch(xi, yi, zi, e, 0);
            wait_done(5);
        end

        // Back-to-back: start held through DONE
        set_dirs(2'b01, 1, 2'b00);
        e = '{-12000, 9000, -400, 1'b0};
        e = model(-12000, 9000, -400);
        launch(-12000, 9000, -400, e, 1);
        wait_done(-1);
        sb.push_back(e);
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_iter", 32'(iter), 0);
        chk("b2b_done", 32'(done), 0);
        start = 1'b0;
        wait_done(-1);

        // Reset in the middle of an operation with err already set
        set_dirs(2'b11, 2, 2'b10);
        e = model(3000, -3000, 500);
        launch(3000, -3000, 500, e, 0);
        for (int n = 0; n < 40 && !(busy && iter == 4'd7); n++) @(negedge clk);
        chk("reached_iter7", 32'(iter), 7);
        chk("err_before_reset", 32'(err), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_done", 32'(done), 0);
        chk("midreset_err", 32'(err), 0);
        chk("midreset_iter", 32'(iter), 0);
        chk("midreset_x_out", x_out, 0);
        chk("midreset_y_out", y_out, 0);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("no_done_after_reset", done_seen, 0);
        $display("reset mid-op done_seen=%0d", done_seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
